burst_rom: RTL and testbench
============================

BURST_ROM -- requirements
Module: burst_rom

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits (1..32).
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port cs  input  1  chip select; low stalls all activity.
REQ-006 Port read_en  input  1  single-word read request.
REQ-007 Port burst_start  input  1  burst read request.
REQ-008 Port addrb  input  ADDR_W  read or burst start address.
REQ-009 Port burst_len  input  ADDR_W+1  burst word count; 0 or a value above DEPTH SHALL be treated as DEPTH.
REQ-010 Port datab  output  DATA_W  registered read data.
REQ-011 Port data_valid  output  1  datab holds a valid word this cycle.
REQ-012 Port busy  output  1  burst in progress.
REQ-013 Port done  output  1  one-cycle pulse with the last burst word.

Function
REQ-014 Contents SHALL be fixed: words 0..7 = 21,ab,33,99,a3,ff,cd,88 (hex); word a>=8 = a. Every value SHALL be zero-extended or truncated to DATA_W.
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 Single read: in IDLE with cs=1, read_en=1 and burst_start=0 sampled at edge N, the block SHALL present datab=word(addrb) and data_valid=1 in cycle N+1 only.
REQ-017 Burst start: in IDLE with cs=1 and burst_start=1, the block SHALL latch addrb and the effective length L and enter BURST. burst_start SHALL take priority over read_en.
REQ-018 In BURST the block SHALL output one word per cycle in which cs=1, at addresses start, start+1, ... modulo DEPTH, with data_valid=1. The first word SHALL appear one cycle after the start edge.
REQ-019 Address wrap: after word DEPTH-1 the next burst address SHALL be 0.
REQ-020 Stall: cs=0 in BURST SHALL hold the address and remaining count and give data_valid=0 on the following cycle; the burst SHALL resume when cs returns to 1.
REQ-021 The done signal SHALL be 1 in the same cycle as the L-th valid word; busy SHALL be 1 from the cycle after the start edge through the done cycle, and 0 afterwards.
REQ-022 The FSM SHALL return to IDLE after the L-th word. A new request SHALL be accepted no earlier than the edge ending the done cycle.
REQ-023 burst_start and read_en SHALL be ignored while busy=1.
REQ-024 Inputs with cs=0 in IDLE SHALL be ignored.
REQ-025 When data_valid=0, datab SHALL be driven per REQ-030 / REQ-031.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, data_valid=0, busy=0 and done=0, with datab per REQ-030 / REQ-031.
REQ-027 Reset SHALL take priority over every request, including mid-burst. An aborted burst SHALL NOT produce done.
REQ-028 In the first cycle after rst deasserts, the block SHALL accept requests.

Configuration
REQ-029 The macro ROM_TRISTATE_EN SHALL select the idle output drive.
REQ-030 With ROM_TRISTATE_EN defined, datab SHALL be all-Z whenever data_valid=0, including during reset.
REQ-031 Without ROM_TRISTATE_EN, datab SHALL be all-zero whenever data_valid=0.

Verification
REQ-032 Defaults: reset, then single read addrb=3 with cs=1, read_en=1 -> next cycle datab=8'h99, data_valid=1; cycle after -> data_valid=0, datab=Z or 0 per macro.
REQ-033 Burst addrb=6, burst_len=4 -> valid words cd,88,21,ab (wrap) on 4 consecutive cycles; done with ab; busy high 4 cycles.
REQ-034 Burst addrb=0, burst_len=8, cs=0 for 2 cycles after the 3rd word -> sequence 21,ab,33, 2 invalid cycles, then 99,a3,ff,cd,88; done with 88.
REQ-035 Simultaneous burst_start=1 and read_en=1 at addrb=5, burst_len=0 -> 8-word burst starting ff. read_en pulsed mid-burst -> no effect.
REQ-036 rst=1 after the 2nd word of a 6-word burst -> next cycle data_valid=0, busy=0, done never asserted; a single read of addrb=1 issued right after reset -> ab.
REQ-037 DATA_W=4, ADDR_W=4: single reads at addresses 1 and 12 -> 4'hb and 4'hc.

Source files
------------

// File: rtl/burst_rom.sv
// burst_rom: fixed-content ROM with single-word reads and wrapping bursts.
// Output data, valid, busy and done are all registered.
// Optional macro ROM_TRISTATE_EN: when defined, datab floats (all-Z) whenever
// data_valid is low; otherwise datab is driven to zero in those cycles.
module burst_rom #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              read_en,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [ADDR_W:0]   burst_len,
  output logic [DATA_W-1:0] datab,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  // Handshake: a request is taken on a rising edge where cs=1 and the block
  // is idle; burst_start wins over read_en. Each word is presented for one
  // cycle with data_valid=1; there is no back-pressure beyond cs.

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  eff_len;

  // Fixed table for the first eight words, identity beyond that.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [31:0] ax;
    logic [31:0] v;
    ax = 32'(a);
    case (ax)
      32'd0:   v = 32'h21;
      32'd1:   v = 32'hab;
      32'd2:   v = 32'h33;
      32'd3:   v = 32'h99;
      32'd4:   v = 32'ha3;
      32'd5:   v = 32'hff;
      32'd6:   v = 32'hcd;
      32'd7:   v = 32'h88;
      default: v = ax;
    endcase
    return v[DATA_W-1:0];
  endfunction

  // Zero or oversize lengths mean a full pass over the ROM.
  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0 || burst_len > DEPTH_L) eff_len = DEPTH_L;
  end

  // Next-state and next-output logic; the first burst word is issued on the
  // start edge itself, so a one-word burst never enters BURST.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    data_d   = '0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs) begin
          if (burst_start) begin
            data_d   = rom_word(addrb);
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            addr_d   = addrb + 1'b1;
            remain_d = eff_len - ONE_L;
            if (eff_len == ONE_L) done_d = 1'b1;
            else state_d = BURST;
          end else if (read_en) begin
            data_d  = rom_word(addrb);
            valid_d = 1'b1;
          end
        end
      end
      BURST: begin
        busy_d = 1'b1;
        if (cs) begin
          data_d   = rom_word(addr_q);
          valid_d  = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - ONE_L;
          if (remain_q == ONE_L) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef ROM_TRISTATE_EN
  assign datab = valid_q ? data_q : {DATA_W{1'bz}};
`else
  assign datab = valid_q ? data_q : '0;
`endif

  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_burst_rom.sv
// tb_burst_rom: directed and randomized checks of burst_rom against a
// transaction-level model (expected word queue per request).
module tb_burst_rom;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs, read_en, burst_start;
  logic [2:0] addrb;
  logic [3:0] burst_len;
  wire  [7:0] datab;
  wire        data_valid, busy, done;

  logic       cs2, read_en2, burst_start2;
  logic [3:0] addrb2;
  logic [4:0] burst_len2;
  wire  [3:0] datab2;
  wire        data_valid2, busy2, done2;

  int errors = 0;
  int checks = 0;

  logic [7:0] tbl [8] = '{8'h21, 8'hab, 8'h33, 8'h99, 8'ha3, 8'hff, 8'hcd, 8'h88};
`ifdef ROM_TRISTATE_EN
  logic [7:0] idle_v = 8'hzz;
`else
  logic [7:0] idle_v = 8'h00;
`endif

  burst_rom #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read_en(read_en), .burst_start(burst_start),
    .addrb(addrb), .burst_len(burst_len), .datab(datab),
    .data_valid(data_valid), .busy(busy), .done(done)
  );

  burst_rom #(.DATA_W(4), .ADDR_W(4)) dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .read_en(read_en2), .burst_start(burst_start2),
    .addrb(addrb2), .burst_len(burst_len2), .datab(datab2),
    .data_valid(data_valid2), .busy(busy2), .done(done2)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] rom8(input int a);
    return tbl[a % 8];
  endfunction

  function automatic logic [3:0] rom4(input int a);
    logic [7:0] w;
    logic [7:0] av;
    av = 8'(a);
    w  = (a < 8) ? tbl[a] : av;
    return w[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic single_read(input int a);
    cs = 1'b1; read_en = 1'b1; burst_start = 1'b0; addrb = 3'(a);
    tick();
    read_en = 1'b0;
    chk("rd_valid", {7'b0, data_valid}, 8'h01);
    chk("rd_data", datab, rom8(a));
    chk("rd_busy", {7'b0, busy}, 8'h00);
    chk("rd_done", {7'b0, done}, 8'h00);
    tick();
    chk("rd_after_valid", {7'b0, data_valid}, 8'h00);
    chk("rd_after_data", datab, idle_v);
  endtask

  // Expected words are the start address plus offsets modulo 8; every cycle
  // that followed a cs=1 edge must pop one word, every stalled one none.
  task automatic burst(input int a, input int len, input int stall_pct,
                       input int stall_at, input int stall_n);
    logic [7:0] exp_q[$];
    logic [7:0] exp;
    int  l;
    int  seen;
    int  stalled;
    bit  last_cs;
    bit  finished;
    seen = 0; stalled = 0; finished = 0;
    l = (len == 0 || len > 8) ? 8 : len;
    for (int i = 0; i < l; i++) exp_q.push_back(rom8(a + i));
    cs = 1'b1; burst_start = 1'b1; read_en = 1'b1;
    addrb = 3'(a); burst_len = 4'(len);
    tick();
    burst_start = 1'b0;
    last_cs = 1'b1;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (last_cs) begin
        exp = exp_q.pop_front();
        seen++;
        chk("burst_valid", {7'b0, data_valid}, 8'h01);
        chk("burst_data", datab, exp);
        chk("burst_done", {7'b0, done}, {7'b0, exp_q.size() == 0});
        chk("burst_busy", {7'b0, busy}, 8'h01);
      end else begin
        chk("stall_valid", {7'b0, data_valid}, 8'h00);
        chk("stall_data", datab, idle_v);
        chk("stall_done", {7'b0, done}, 8'h00);
        chk("stall_busy", {7'b0, busy}, 8'h01);
      end
      if (exp_q.size() == 0) begin
        finished = 1'b1;
      end else begin
        read_en     = 1'($urandom_range(0, 1));
        burst_start = 1'($urandom_range(0, 1));
        addrb       = 3'($urandom_range(0, 7));
        burst_len   = 4'($urandom_range(0, 15));
        if (seen == stall_at && stalled < stall_n) begin
          cs = 1'b0;
          stalled++;
        end else begin
          cs = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
        end
        last_cs = cs;
        tick();
      end
    end
    if (!finished) chk("burst_timeout", 8'h00, 8'h01);
    cs = 1'b1; read_en = 1'b0; burst_start = 1'b0;
    tick();
    chk("end_busy", {7'b0, busy}, 8'h00);
    chk("end_valid", {7'b0, data_valid}, 8'h00);
    chk("end_done", {7'b0, done}, 8'h00);
    chk("end_data", datab, idle_v);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; read_en = 1'b0; burst_start = 1'b0;
    addrb = '0; burst_len = '0;
    cs2 = 1'b1; read_en2 = 1'b0; burst_start2 = 1'b0; addrb2 = '0; burst_len2 = '0;
    tick();
    tick();
    chk("reset_valid", {7'b0, data_valid}, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);
    chk("reset_done", {7'b0, done}, 8'h00);
    chk("reset_data", datab, idle_v);
    rst = 1'b0;

    // single read right after reset
    single_read(3);

    // wrapping burst, full-length stalled burst, len=0 with read_en collision
    burst(6, 4, 0, -1, 0);
    burst(0, 8, 0, 3, 2);
    burst(5, 0, 0, -1, 0);
    burst(2, 1, 0, -1, 0);
    burst(7, 12, 0, -1, 0);

    // cs=0 in idle ignores requests
    cs = 1'b0; read_en = 1'b1; burst_start = 1'b1; addrb = 3'd4; burst_len = 4'd3;
    tick();
    chk("cs0_valid", {7'b0, data_valid}, 8'h00);
    chk("cs0_busy", {7'b0, busy}, 8'h00);
    cs = 1'b1; read_en = 1'b0; burst_start = 1'b0;
    tick();
    chk("cs0_after_valid", {7'b0, data_valid}, 8'h00);
    chk("cs0_after_busy", {7'b0, busy}, 8'h00);

    // reset in the middle of a 6-word burst
    cs = 1'b1; burst_start = 1'b1; read_en = 1'b0; addrb = 3'd0; burst_len = 4'd6;
    tick();
    burst_start = 1'b0;
    chk("abort_w1", datab, rom8(0));
    tick();
    chk("abort_w2", datab, rom8(1));
    chk("abort_w2_done", {7'b0, done}, 8'h00);
    rst = 1'b1;
    tick();
    chk("abort_valid", {7'b0, data_valid}, 8'h00);
    chk("abort_busy", {7'b0, busy}, 8'h00);
    chk("abort_done", {7'b0, done}, 8'h00);
    chk("abort_data", datab, idle_v);
    rst = 1'b0;
    single_read(1);
    chk("abort_later_done", {7'b0, done}, 8'h00);

    // randomized bursts and reads
    for (int k = 0; k < 20; k++) begin
      burst($urandom_range(0, 7), $urandom_range(0, 15), 30, -1, 0);
      single_read($urandom_range(0, 7));
    end

    // narrow/deep instance
    read_en2 = 1'b1; addrb2 = 4'd1;
    tick();
    chk("w4_a1_valid", {7'b0, data_valid2}, 8'h01);
    chk("w4_a1_data", {4'b0, datab2}, {4'b0, rom4(1)});
    addrb2 = 4'd12;
    tick();
    chk("w4_a12_valid", {7'b0, data_valid2}, 8'h01);
    chk("w4_a12_data", {4'b0, datab2}, {4'b0, rom4(12)});
    read_en2 = 1'b0;
    tick();
    chk("w4_idle_valid", {7'b0, data_valid2}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
